// File: rtl/avaliador_ativos_pkg.sv
// Shared definitions for the active-node evaluator: FSM encoding, default
// entry field widths and the output slot packing helper.
package avaliador_ativos_pkg;

  localparam int ADDR_WIDTH_DEF      = 10;
  localparam int DISTANCIA_WIDTH_DEF = 6;
  localparam int NUM_NA_DEF          = 4;
  localparam int NUM_ATIVOS_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSCA_MIN = 2'd1,
    SELECIONA = 2'd2,
    PRONTO    = 2'd3
  } estado_t;

  // LSB of output slot k inside a packed field vector of w-bit slots
  function automatic int slot_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/avaliador_ativos_if.sv
// Bundle between the control/neighbour blocks (master) and the evaluator (slave).
interface avaliador_ativos_if
  import avaliador_ativos_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DISTANCIA_WIDTH = DISTANCIA_WIDTH_DEF,
  parameter int NUM_NA          = NUM_NA_DEF
);
  logic                              cme_expandir_in;
  logic                              lvv_atualizar_in;
  logic [ADDR_WIDTH-1:0]             lvv_endereco_in;
  logic [DISTANCIA_WIDTH-1:0]        lvv_distancia_in;
  logic [ADDR_WIDTH-1:0]             lvv_anterior_in;
  logic                              lvv_desativar_in;
  logic [ADDR_WIDTH-1:0]             lvv_desativar_addr_in;
  logic                              aa_ocupado_out;
  logic                              aa_pronto_out;
  logic [NUM_NA-1:0]                 aa_aprovado_out;
  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_out;
  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_out;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out;
  logic                              aa_vazio_out;
  logic                              aa_cheio_out;
  logic                              aa_erro_out;

  modport master (
    output cme_expandir_in, lvv_atualizar_in, lvv_endereco_in, lvv_distancia_in,
           lvv_anterior_in, lvv_desativar_in, lvv_desativar_addr_in,
    input  aa_ocupado_out, aa_pronto_out, aa_aprovado_out, aa_endereco_out,
           aa_anterior_data_out, aa_distancia_out, aa_vazio_out, aa_cheio_out, aa_erro_out
  );

  modport slave (
    input  cme_expandir_in, lvv_atualizar_in, lvv_endereco_in, lvv_distancia_in,
           lvv_anterior_in, lvv_desativar_in, lvv_desativar_addr_in,
    output aa_ocupado_out, aa_pronto_out, aa_aprovado_out, aa_endereco_out,
           aa_anterior_data_out, aa_distancia_out, aa_vazio_out, aa_cheio_out, aa_erro_out
  );
endinterface

// File: rtl/avaliador_ativos_tabela.sv
// Open-set table: entry registers, address match, lowest-free-slot encoder,
// full/empty flags and one indexed read port for the scanning FSM.
module avaliador_ativos_tabela #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int NUM_ATIVOS      = 16,
  parameter int IDX_W           = $clog2(NUM_ATIVOS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       atualizar,
  input  logic [ADDR_WIDTH-1:0]      upd_addr,
  input  logic [DISTANCIA_WIDTH-1:0] upd_dist,
  input  logic [ADDR_WIDTH-1:0]      upd_ant,
  input  logic                       desativar,
  input  logic [ADDR_WIDTH-1:0]      des_addr,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic                       rd_valid,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [DISTANCIA_WIDTH-1:0] rd_dist,
  output logic [ADDR_WIDTH-1:0]      rd_ant,
  output logic                       vazio,
  output logic                       cheio,
  output logic                       overflow
);
  logic [NUM_ATIVOS-1:0]                      valid;
  logic [NUM_ATIVOS-1:0][ADDR_WIDTH-1:0]      addr_q;
  logic [NUM_ATIVOS-1:0][ADDR_WIDTH-1:0]      ant_q;
  logic [NUM_ATIVOS-1:0][DISTANCIA_WIDTH-1:0] dist_q;
  logic [NUM_ATIVOS-1:0]                      hit_vec, des_vec;
  logic [IDX_W-1:0]                           free_idx;
  logic                                       has_free, hit, upd_en, des_en;

  // Address match vectors for the insert/improve and remove requests
  always_comb begin
    hit_vec = '0;
    des_vec = '0;
    for (int i = 0; i < NUM_ATIVOS; i++) begin
      hit_vec[i] = valid[i] && (addr_q[i] == upd_addr);
      des_vec[i] = valid[i] && (addr_q[i] == des_addr);
    end
  end

  // Lowest-index free slot, from pre-cycle state only
  always_comb begin
    free_idx = '0;
    has_free = 1'b0;
    for (int i = NUM_ATIVOS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
        has_free = 1'b1;
      end
    end
  end

  // A remove of the same address in the same cycle cancels the insert
  assign hit      = |hit_vec;
  assign des_en   = wr_en && desativar;
  assign upd_en   = wr_en && atualizar && !(desativar && (des_addr == upd_addr));
  assign overflow = upd_en && !hit && !has_free;

  // Entry updates: remove, strict improvement, or insert into the free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      addr_q <= '0;
      ant_q  <= '0;
      dist_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ATIVOS; i++) begin
        if (des_en && des_vec[i]) begin
          valid[i] <= 1'b0;
        end else if (upd_en && hit_vec[i]) begin
          if (upd_dist < dist_q[i]) begin
            dist_q[i] <= upd_dist;
            ant_q[i]  <= upd_ant;
          end
        end else if (upd_en && !hit && has_free && (free_idx == IDX_W'(i))) begin
          valid[i]  <= 1'b1;
          addr_q[i] <= upd_addr;
          dist_q[i] <= upd_dist;
          ant_q[i]  <= upd_ant;
        end
      end
    end
  end

  assign vazio    = ~|valid;
  assign cheio    = &valid;
  assign rd_valid = valid[rd_idx];
  assign rd_addr  = addr_q[rd_idx];
  assign rd_dist  = dist_q[rd_idx];
  assign rd_ant   = ant_q[rd_idx];

endmodule

// File: rtl/avaliador_ativos.sv
// Active-node evaluator: two-pass scan (minimum search, then selection of up
// to NUM_NA entries at that minimum) over the open-set table.
module avaliador_ativos
  import avaliador_ativos_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DISTANCIA_WIDTH = DISTANCIA_WIDTH_DEF,
  parameter int NUM_NA          = NUM_NA_DEF,
  parameter int NUM_ATIVOS      = NUM_ATIVOS_DEF
) (
  input logic         clk,
  input logic         rst_n,
  avaliador_ativos_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ATIVOS);
  localparam int SW    = $clog2(NUM_NA + 1);

  estado_t                           estado, prox;
  logic [IDX_W-1:0]                  idx;
  logic [DISTANCIA_WIDTH-1:0]        min_q;
  logic [SW-1:0]                     slot;
  logic [NUM_NA-1:0]                 aprovado_q;
  logic [ADDR_WIDTH*NUM_NA-1:0]      end_q, ant_q;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] dist_q;
  logic                              erro_q, ocupado, pronto, ultimo;
  logic                              rd_valid, vazio, cheio, overflow;
  logic [ADDR_WIDTH-1:0]             rd_addr, rd_ant;
  logic [DISTANCIA_WIDTH-1:0]        rd_dist;

  avaliador_ativos_tabela #(
    .ADDR_WIDTH(ADDR_WIDTH), .DISTANCIA_WIDTH(DISTANCIA_WIDTH),
    .NUM_ATIVOS(NUM_ATIVOS), .IDX_W(IDX_W)
  ) u_tabela (
    .clk(clk), .rst_n(rst_n), .wr_en(!ocupado),
    .atualizar(bus.lvv_atualizar_in), .upd_addr(bus.lvv_endereco_in),
    .upd_dist(bus.lvv_distancia_in), .upd_ant(bus.lvv_anterior_in),
    .desativar(bus.lvv_desativar_in), .des_addr(bus.lvv_desativar_addr_in),
    .rd_idx(idx), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_dist(rd_dist),
    .rd_ant(rd_ant), .vazio(vazio), .cheio(cheio), .overflow(overflow)
  );

  assign ultimo = (idx == IDX_W'(NUM_ATIVOS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= prox;
  end

  // Next-state logic; an empty table skips straight to PRONTO
  always_comb begin
    prox = estado;
    case (estado)
      IDLE:      if (bus.cme_expandir_in) prox = vazio ? PRONTO : BUSCA_MIN;
      BUSCA_MIN: if (ultimo) prox = SELECIONA;
      SELECIONA: if (ultimo) prox = PRONTO;
      PRONTO:    prox = IDLE;
      default:   prox = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ocupado = (estado == BUSCA_MIN) || (estado == SELECIONA);
    pronto  = (estado == PRONTO);
  end

  // Scan index, running minimum and approved-slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      min_q      <= '0;
      slot       <= '0;
      aprovado_q <= '0;
      end_q      <= '0;
      ant_q      <= '0;
      dist_q     <= '0;
    end else begin
      case (estado)
        IDLE: if (bus.cme_expandir_in) begin
          idx        <= '0;
          min_q      <= '1;
          slot       <= '0;
          aprovado_q <= '0;
          end_q      <= '0;
          ant_q      <= '0;
          dist_q     <= '0;
        end
        BUSCA_MIN: begin
          if (rd_valid && (rd_dist < min_q)) min_q <= rd_dist;
          idx <= ultimo ? '0 : idx + 1'b1;
          if (ultimo) slot <= '0;
        end
        SELECIONA: begin
          if (rd_valid && (rd_dist == min_q) && (slot < SW'(NUM_NA))) begin
            for (int k = 0; k < NUM_NA; k++) begin
              if (slot == SW'(k)) begin
                aprovado_q[k] <= 1'b1;
                end_q[slot_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH]            <= rd_addr;
                ant_q[slot_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH]            <= rd_ant;
                dist_q[slot_lsb(k, DISTANCIA_WIDTH) +: DISTANCIA_WIDTH] <= rd_dist;
              end
            end
            slot <= slot + 1'b1;
          end
          idx <= ultimo ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky error: table overflow or any write attempted during a scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) erro_q <= 1'b0;
    else erro_q <= erro_q | overflow |
                   (ocupado & (bus.lvv_atualizar_in | bus.lvv_desativar_in));
  end

  assign bus.aa_ocupado_out       = ocupado;
  assign bus.aa_pronto_out        = pronto;
  assign bus.aa_aprovado_out      = aprovado_q;
  assign bus.aa_endereco_out      = end_q;
  assign bus.aa_anterior_data_out = ant_q;
  assign bus.aa_distancia_out     = dist_q;
  assign bus.aa_vazio_out         = vazio;
  assign bus.aa_cheio_out         = cheio;
  assign bus.aa_erro_out          = erro_q;

endmodule

// File: tb/tb_avaliador_ativos.sv
// Self-checking bench for avaliador_ativos with a behavioural open-set model.
module tb_avaliador_ativos;
  localparam int AW = 10, DW = 6, NA = 4, N = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avaliador_ativos_if bus ();
  avaliador_ativos dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_err = 0;

  // Reference open set: plain arrays, updated by the rules of the block
  bit            mv  [N];
  logic [AW-1:0] ma  [N];
  logic [AW-1:0] mant[N];
  logic [DW-1:0] md  [N];
  bit            merr;
  bit            mbusy;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mv[i] = 0; ma[i] = 0; mant[i] = 0; md[i] = 0; end
    merr = 0;
  endtask

  task automatic model_write(input bit u, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [AW-1:0] an, input bit x, input logic [AW-1:0] xa);
    int hit, fr;
    hit = -1; fr = -1;
    if (mbusy) begin
      if (u || x) merr = 1;
      return;
    end
    for (int i = 0; i < N; i++) if (mv[i] && ma[i] == a) hit = i;
    for (int i = N - 1; i >= 0; i--) if (!mv[i]) fr = i;
    if (u && !(x && xa == a)) begin
      if (hit >= 0) begin
        if (d < md[hit]) begin md[hit] = d; mant[hit] = an; end
      end else if (fr >= 0) begin
        mv[fr] = 1; ma[fr] = a; md[fr] = d; mant[fr] = an;
      end else merr = 1;
    end
    if (x) for (int i = 0; i < N; i++) if (mv[i] && ma[i] == xa) mv[i] = 0;
  endtask

  task automatic model_expand(output logic [NA-1:0] ap, output logic [AW*NA-1:0] ea,
                              output logic [AW*NA-1:0] aa, output logic [DW*NA-1:0] da,
                              output bit empty);
    int mn, k;
    mn = 1 << DW; k = 0; ap = '0; ea = '0; aa = '0; da = '0; empty = 1;
    for (int i = 0; i < N; i++) if (mv[i]) begin
      empty = 0;
      if (int'(md[i]) < mn) mn = int'(md[i]);
    end
    for (int i = 0; i < N; i++) if (mv[i] && int'(md[i]) == mn && k < NA) begin
      ap[k] = 1'b1; ea[k*AW +: AW] = ma[i]; aa[k*AW +: AW] = mant[i]; da[k*DW +: DW] = md[i];
      k++;
    end
  endtask

  task automatic clear_inputs();
    bus.cme_expandir_in = 0; bus.lvv_atualizar_in = 0; bus.lvv_endereco_in = '0;
    bus.lvv_distancia_in = '0; bus.lvv_anterior_in = '0; bus.lvv_desativar_in = 0;
    bus.lvv_desativar_addr_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0; mbusy = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // One write cycle, called at a falling edge; returns at the next falling edge
  task automatic drive_write(input bit u, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [AW-1:0] an, input bit x, input logic [AW-1:0] xa);
    bus.lvv_atualizar_in = u; bus.lvv_endereco_in = a; bus.lvv_distancia_in = d;
    bus.lvv_anterior_in = an; bus.lvv_desativar_in = x; bus.lvv_desativar_addr_in = xa;
    model_write(u, a, d, an, x, xa);
    @(negedge clk);
    bus.lvv_atualizar_in = 0; bus.lvv_desativar_in = 0;
  endtask

  task automatic check_flags(input string nm);
    logic [2:0] exp_f;
    bit e;
    e = 1; for (int i = 0; i < N; i++) if (mv[i]) e = 0;
    exp_f = {e, 1'b1, merr};
    for (int i = 0; i < N; i++) if (!mv[i]) exp_f[1] = 1'b0;
    n_cmp++;
    if ({bus.aa_vazio_out, bus.aa_cheio_out, bus.aa_erro_out} !== exp_f) begin
      n_err++;
      $display("FAIL %s flags vazio/cheio/erro: got %b expected %b", nm,
               {bus.aa_vazio_out, bus.aa_cheio_out, bus.aa_erro_out}, exp_f);
    end
  endtask

  // Waits for pronto (bounded) after the request cycle, then checks latency and slots
  task automatic finish_expand(input string nm, input int n0, input logic [NA-1:0] ap,
                               input logic [AW*NA-1:0] ea, input logic [AW*NA-1:0] aa,
                               input logic [DW*NA-1:0] da, input bit empty, input int busy0);
    int n, bc;
    n = n0; bc = busy0;
    while (!bus.aa_pronto_out && n < 100) begin
      if (bus.aa_ocupado_out) bc++;
      @(negedge clk); n++;
    end
    mbusy = 0;
    n_cmp++;
    if (n !== (empty ? 1 : 2 * N + 1)) begin
      n_err++; $display("FAIL %s latency: got %0d expected %0d", nm, n, empty ? 1 : 2 * N + 1);
    end
    n_cmp++;
    if (bc !== (empty ? 0 : 2 * N)) begin
      n_err++; $display("FAIL %s ocupado cycles: got %0d expected %0d", nm, bc, empty ? 0 : 2 * N);
    end
    n_cmp++;
    if (bus.aa_aprovado_out !== ap) begin
      n_err++; $display("FAIL %s aprovado: got %b expected %b", nm, bus.aa_aprovado_out, ap);
    end
    n_cmp++;
    if ({bus.aa_endereco_out, bus.aa_anterior_data_out, bus.aa_distancia_out} !== {ea, aa, da}) begin
      n_err++;
      $display("FAIL %s slots end/ant/dist: got %h/%h/%h expected %h/%h/%h", nm,
               bus.aa_endereco_out, bus.aa_anterior_data_out, bus.aa_distancia_out, ea, aa, da);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.aa_pronto_out !== 1'b0 || bus.aa_aprovado_out !== ap) begin
      n_err++; $display("FAIL %s pronto pulse/hold: got %b/%b expected 0/%b", nm,
                        bus.aa_pronto_out, bus.aa_aprovado_out, ap);
    end
  endtask

  task automatic expand_check(input string nm);
    logic [NA-1:0] ap; logic [AW*NA-1:0] ea, aa; logic [DW*NA-1:0] da; bit empty;
    model_expand(ap, ea, aa, da, empty);
    bus.cme_expandir_in = 1;
    @(negedge clk);
    bus.cme_expandir_in = 0;
    finish_expand(nm, 1, ap, ea, aa, da, empty, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.aa_ocupado_out, bus.aa_pronto_out, bus.aa_aprovado_out, bus.aa_endereco_out,
         bus.aa_anterior_data_out, bus.aa_distancia_out} !== '0) begin
      n_err++; $display("FAIL reset outputs: got nonzero expected all 0");
    end
    check_flags("reset");
  endtask

  task automatic test_single();
    do_reset();
    drive_write(1, 10'd5, 6'd0, 10'd5, 0, '0);
    check_flags("single insert");
    expand_check("single expand");
  endtask

  task automatic test_min_select();
    do_reset();
    drive_write(1, 10'd10, 6'd3, 10'd1, 0, '0);
    drive_write(1, 10'd11, 6'd2, 10'd2, 0, '0);
    drive_write(1, 10'd12, 6'd2, 10'd3, 0, '0);
    drive_write(1, 10'd13, 6'd7, 10'd4, 0, '0);
    expand_check("min select");
    n_cmp++;
    if (bus.aa_aprovado_out !== 4'b0011) begin
      n_err++; $display("FAIL min select const: got %b expected 0011", bus.aa_aprovado_out);
    end
    // improve: non-strict is ignored, strict improvement overwrites dist and predecessor
    drive_write(1, 10'd10, 6'd4, 10'd8, 0, '0);
    drive_write(1, 10'd10, 6'd3, 10'd8, 0, '0);
    drive_write(1, 10'd10, 6'd1, 10'd9, 0, '0);
    expand_check("improve");
    n_cmp++;
    if (bus.aa_endereco_out[AW-1:0] !== 10'd10 || bus.aa_anterior_data_out[AW-1:0] !== 10'd9) begin
      n_err++; $display("FAIL improve const: got %0d/%0d expected 10/9",
                        bus.aa_endereco_out[AW-1:0], bus.aa_anterior_data_out[AW-1:0]);
    end
  endtask

  task automatic test_many_min();
    do_reset();
    drive_write(1, 10'd40, 6'd9, 10'd1, 0, '0);
    for (int i = 0; i < 6; i++) drive_write(1, 10'(20 + i), 6'd2, 10'(i), 0, '0);
    expand_check("six at min first");
    for (int i = 0; i < 4; i++) drive_write(0, '0, '0, '0, 1, 10'(20 + i));
    check_flags("desativar four");
    expand_check("six at min second");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < N; i++) drive_write(1, 10'(100 + i), 6'(i % 5 + 1), 10'(i), 0, '0);
    check_flags("filled");
    drive_write(1, 10'd200, 6'd0, 10'd0, 0, '0);
    check_flags("17th dropped");
    // freed slot is not reusable in the same cycle
    drive_write(1, 10'd300, 6'd0, 10'd0, 1, 10'd101);
    check_flags("free same cycle");
    drive_write(1, 10'd100, 6'd0, 10'd7, 1, 10'd100);
    check_flags("upd+des same addr");
    drive_write(0, '0, '0, '0, 1, 10'd999);
    expand_check("after overflow");
  endtask

  task automatic test_empty_busy();
    logic [NA-1:0] ap; logic [AW*NA-1:0] ea, aa; logic [DW*NA-1:0] da; bit empty;
    do_reset();
    expand_check("empty expand");
    drive_write(1, 10'd77, 6'd4, 10'd3, 0, '0);
    model_expand(ap, ea, aa, da, empty);
    bus.cme_expandir_in = 1;
    @(negedge clk);
    bus.cme_expandir_in = 0;
    @(negedge clk);
    mbusy = 1;
    drive_write(1, 10'd78, 6'd0, 10'd0, 1, 10'd77);
    finish_expand("busy write", 3, ap, ea, aa, da, empty, 2);
    check_flags("busy write");
    expand_check("table after busy");
    // reset in the middle of a scan
    bus.cme_expandir_in = 1;
    @(negedge clk);
    bus.cme_expandir_in = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.aa_ocupado_out, bus.aa_pronto_out, bus.aa_aprovado_out, bus.aa_vazio_out,
         bus.aa_cheio_out, bus.aa_erro_out} !== {2'b00, 4'b0000, 3'b100} ||
        {bus.aa_endereco_out, bus.aa_anterior_data_out, bus.aa_distancia_out} !== '0) begin
      n_err++; $display("FAIL midscan reset: got ocup=%b err=%b vazio=%b expected 0/0/1",
                        bus.aa_ocupado_out, bus.aa_erro_out, bus.aa_vazio_out);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 11) == 0) expand_check("random expand");
      else begin
        drive_write($urandom_range(0, 9) != 0, 10'($urandom_range(0, 21)),
                    6'($urandom_range(0, 15)), 10'($urandom), $urandom_range(0, 2) == 0,
                    10'($urandom_range(0, 21)));
        check_flags("random write");
      end
    end
    expand_check("random final");
  endtask

  initial begin
    rst_n = 0; mbusy = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_min_select();
    test_many_min();
    test_overflow();
    test_empty_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
